// File: rtl/mem_ctrl.sv
// ----------------------------------------------------------------------------
// mem_ctrl
// ----------------------------------------------------------------------------
// Request sequencer that sits directly in front of the 256 x 8 single-port
// byte RAM. It takes byte or halfword loads and stores from the CPU datapath
// over a valid/ready handshake. Each request becomes one or two RAM beats, and
// the controller returns one response pulse per request. Halfwords are
// little-endian: the low byte is at addr and the high byte is at addr+1.
//
// Parameters
//   ADDR_W  RAM address width (8 for the current RAM)
//   RD_LAT  cycles from a RAM read beat to valid ram_rdata (>= 1)
//
// Optional feature macro: MEM_CTRL_WRAP_ERR_EN
//   defined   : a halfword request at the top address issues no RAM beat and
//               completes at once with rsp_err=1, rsp_rdata=0
//   undefined : rsp_err is tied 0; a halfword at the top address wraps to 0
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   req_valid / req_ready    request handshake
//   req_we, req_wide         0/1 = load/store, 0/1 = byte/halfword
//   req_addr, req_wdata      byte address, store data (byte uses [7:0])
//   rsp_valid                one-cycle completion pulse
//   rsp_rdata, rsp_err       load result (zero-extended for bytes), error flag
//   ram_en, ram_r_w          RAM enable, 0 = read / 1 = write
//   ram_addr, ram_wdata      RAM address and write data
//   ram_rdata                RAM registered read data
// ----------------------------------------------------------------------------
module mem_ctrl #(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_wide,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              rsp_valid,
    output logic [15:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              ram_en,
    output logic              ram_r_w,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    // The WAIT counter only has to reach RD_LAT-1.
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state;
    logic              beat;          // 0 = byte at addr, 1 = byte at addr+1
    logic [CNT_W-1:0]  wait_cnt;
    logic              lat_we;
    logic              lat_wide;
    logic [ADDR_W-1:0] lat_addr;
    logic [7:0]        lat_wdata_hi;  // only the high byte is needed after accept
    logic [7:0]        lat_lo;        // low byte of a halfword load
    logic              last_beat;

    // Builds the load result from the byte arriving now and the stored low byte.
    function automatic logic [15:0] merge_rdata(input logic       wide,
                                                input logic [7:0] lo,
                                                input logic [7:0] rd);
        merge_rdata = wide ? {rd, lo} : {8'h00, rd};
    endfunction

    assign last_beat = !lat_wide || beat;

    // Ready is decoded from state alone, and it is also held low while rst is high.
    assign req_ready = (state == IDLE) && !rst;

`ifdef MEM_CTRL_WRAP_ERR_EN
    logic err_q;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // All outputs are registered. Each transition loads the outputs that belong
    // to the state being entered, so outputs depend only on registered state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            beat         <= 1'b0;
            wait_cnt     <= '0;
            lat_we       <= 1'b0;
            lat_wide     <= 1'b0;
            lat_addr     <= '0;
            lat_wdata_hi <= 8'h00;
            lat_lo       <= 8'h00;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 16'h0000;
            ram_en       <= 1'b0;
            ram_r_w      <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= 8'h00;
`ifdef MEM_CTRL_WRAP_ERR_EN
            err_q        <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            ram_en    <= 1'b0;
`ifdef MEM_CTRL_WRAP_ERR_EN
            err_q     <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we       <= req_we;
                        lat_wide     <= req_wide;
                        lat_addr     <= req_addr;
                        lat_wdata_hi <= req_wdata[15:8];
                        lat_lo       <= 8'h00;
                        beat         <= 1'b0;
`ifdef MEM_CTRL_WRAP_ERR_EN
                        // A halfword at the top address would wrap. Reject it without touching the RAM.
                        if (req_wide && (req_addr == {ADDR_W{1'b1}})) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= 16'h0000;
                            err_q     <= 1'b1;
                        end else
`endif
                        begin
                            state     <= ISSUE;
                            ram_en    <= 1'b1;
                            ram_r_w   <= req_we;
                            ram_addr  <= req_addr;
                            ram_wdata <= req_wdata[7:0];
                        end
                    end
                end

                ISSUE: begin
                    if (lat_we) begin
                        if (last_beat) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= 16'h0000;
                        end else begin
                            // Second store beat. The address wraps modulo 2^ADDR_W.
                            beat      <= 1'b1;
                            ram_en    <= 1'b1;
                            ram_r_w   <= 1'b1;
                            ram_addr  <= lat_addr + ADDR_W'(1);
                            ram_wdata <= lat_wdata_hi;
                        end
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end
                end

                WAIT: begin
                    if (wait_cnt == CNT_LAST) begin
                        if (last_beat) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= merge_rdata(lat_wide, lat_lo, ram_rdata);
                        end else begin
                            lat_lo    <= ram_rdata;
                            beat      <= 1'b1;
                            state     <= ISSUE;
                            ram_en    <= 1'b1;
                            ram_r_w   <= 1'b0;
                            ram_addr  <= lat_addr + ADDR_W'(1);
                            ram_wdata <= lat_wdata_hi;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for mem_ctrl. It builds two instances: one with
// RD_LAT=1 and one with RD_LAT=2. Each instance has its own RAM model
// (256 x 8, registered read). The main checks come from a vector table.
// Hand-written sequences cover back-to-back requests and reset during a
// request. A randomized stream is then checked against a byte-array
// reference model.
// ----------------------------------------------------------------------------
module tb_mem_ctrl;

`ifdef MEM_CTRL_WRAP_ERR_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_load;
    logic        rv1, rv2;
    logic        req_we, req_wide;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;

    logic        rr1, rsp_valid1, rsp_err1, ram_en1, ram_r_w1;
    logic [15:0] rsp_rdata1;
    logic [7:0]  ram_addr1, ram_wdata1, ram_rdata1;
    logic        rr2, rsp_valid2, rsp_err2, ram_en2, ram_r_w2;
    logic [15:0] rsp_rdata2;
    logic [7:0]  ram_addr2, ram_wdata2, ram_rdata2, rd2a;

    logic [7:0]  mem1 [256];
    logic [7:0]  mem2 [256];
    logic [7:0]  ref_mem [256];

    int n_checks = 0;
    int n_fail = 0;
    int pulses1 = 0;
    int wide_pulses = 0;
    logic prev1 = 1'b0, prev2 = 1'b0;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(8), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rr1),
        .req_we(req_we), .req_wide(req_wide), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
        .ram_en(ram_en1), .ram_r_w(ram_r_w1), .ram_addr(ram_addr1),
        .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
    );

    mem_ctrl #(.ADDR_W(8), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(rv2), .req_ready(rr2),
        .req_we(req_we), .req_wide(req_wide), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2),
        .ram_en(ram_en2), .ram_r_w(ram_r_w2), .ram_addr(ram_addr2),
        .ram_wdata(ram_wdata2), .ram_rdata(ram_rdata2)
    );

    // RAM models. mem1 holds the pattern i*7+3, and mem2 holds two known bytes.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem1[i] <= 8'(i * 7 + 3);
        end else if (ram_en1) begin
            if (ram_r_w1) mem1[ram_addr1] <= ram_wdata1;
            else          ram_rdata1 <= mem1[ram_addr1];
        end
    end

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++)
                mem2[i] <= (i == 8'h33) ? 8'h5A : ((i == 8'h34) ? 8'hC3 : 8'h00);
        end else if (ram_en2) begin
            if (ram_r_w2) mem2[ram_addr2] <= ram_wdata2;
            else          rd2a <= mem2[ram_addr2];
        end
        ram_rdata2 <= rd2a;  // extra read stage for RD_LAT=2
    end

    // Response pulse monitor.
    always @(negedge clk) begin
        prev1 <= rsp_valid1;
        prev2 <= rsp_valid2;
        if (rsp_valid1) pulses1 <= pulses1 + 1;
        if ((rsp_valid1 && prev1) || (rsp_valid2 && prev2)) wide_pulses <= wide_pulses + 1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic rdy(input bit s);
        return s ? rr2 : rr1;
    endfunction

    // Reference model. It works on whole requests over a byte array.
    task automatic model(input logic we, input logic wide, input logic [7:0] addr,
                         input logic [15:0] wdata, input int rdlat,
                         output logic [15:0] rdata, output logic err,
                         output int lat, output int beats);
        int n;
        int a;
        err = WRAP_EN && wide && (addr == 8'hFF);
        rdata = 16'h0000;
        if (err) begin
            lat = 1;
            beats = 0;
            return;
        end
        n = wide ? 2 : 1;
        for (int b = 0; b < n; b++) begin
            a = (int'(addr) + b) % 256;
            if (we) ref_mem[a] = wdata[8*b +: 8];
            else    rdata[8*b +: 8] = ref_mem[a];
        end
        lat = 1 + n * (we ? 1 : 1 + rdlat);
        beats = n;
    endtask

    // Call this task on a negedge. It returns on the negedge of the response cycle.
    // lat counts cycles from the accept edge, beats counts ram_en cycles, and
    // busy_bad counts cycles with req_ready high while the request was in flight.
    task automatic do_req(input bit s, input logic we, input logic wide,
                          input logic [7:0] addr, input logic [15:0] wdata, input bit hold,
                          output logic [15:0] rdata, output logic err,
                          output int lat, output int beats, output int busy_bad);
        int n;
        req_we = we; req_wide = wide; req_addr = addr; req_wdata = wdata;
        if (s) rv2 = 1'b1; else rv1 = 1'b1;
        n = 0;
        lat = 0; beats = 0; busy_bad = 0; rdata = 16'h0; err = 1'b0;
        while (!rdy(s) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("accept_timeout", 32'(n), 32'd0);
            rv1 = 1'b0; rv2 = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin rv1 = 1'b0; rv2 = 1'b0; end
        lat = 1;
        while (!(s ? rsp_valid2 : rsp_valid1) && lat < 200) begin
            if (s ? ram_en2 : ram_en1) beats++;
            if (rdy(s)) busy_bad++;
            @(negedge clk);
            lat++;
        end
        if (rdy(s)) busy_bad++;
        rdata = s ? rsp_rdata2 : rsp_rdata1;
        err   = s ? rsp_err2 : rsp_err1;
    endtask

    typedef struct {
        bit          sel;
        logic        we;
        logic        wide;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_beats;
    } vec_t;

    initial begin
        vec_t        vecs [13];
        logic [15:0] got_rd, m_rd;
        logic        got_err, m_err;
        int          got_lat, got_beats, bad, m_lat, m_beats, p0, mism;
        logic        r_we, r_wide, r_hold;
        logic [7:0]  r_addr;
        logic [15:0] r_wdata;

        vecs[0]  = '{0, 1, 0, 8'h10, 16'h00A5, 16'h0000, 0, 2, 1};
        vecs[1]  = '{0, 0, 0, 8'h10, 16'h0000, 16'h00A5, 0, 3, 1};
        vecs[2]  = '{0, 1, 1, 8'h20, 16'hBEEF, 16'h0000, 0, 3, 2};
        vecs[3]  = '{0, 0, 1, 8'h20, 16'h0000, 16'hBEEF, 0, 5, 2};
        vecs[4]  = '{0, 1, 1, 8'hFF, 16'h1234, 16'h0000, WRAP_EN, WRAP_EN ? 1 : 3, WRAP_EN ? 0 : 2};
        vecs[5]  = '{0, 0, 1, 8'hFF, 16'h0000, WRAP_EN ? 16'h0000 : 16'h1234, WRAP_EN,
                     WRAP_EN ? 1 : 5, WRAP_EN ? 0 : 2};
        vecs[6]  = '{0, 1, 0, 8'hFF, 16'h0077, 16'h0000, 0, 2, 1};
        vecs[7]  = '{0, 0, 0, 8'hFF, 16'h0000, 16'h0077, 0, 3, 1};
        vecs[8]  = '{1, 0, 0, 8'h33, 16'h0000, 16'h005A, 0, 4, 1};
        vecs[9]  = '{1, 0, 1, 8'h33, 16'h0000, 16'hC35A, 0, 7, 2};
        vecs[10] = '{0, 0, 0, 8'h21, 16'h0000, 16'h00BE, 0, 3, 1};
        vecs[11] = '{0, 1, 0, 8'h21, 16'hFF99, 16'h0000, 0, 2, 1};
        vecs[12] = '{0, 0, 1, 8'h20, 16'h0000, 16'h99EF, 0, 5, 2};

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);

        rst = 1'b1; mem_load = 1'b1; rv1 = 1'b0; rv2 = 1'b0;
        req_we = 1'b0; req_wide = 1'b0; req_addr = 8'h00; req_wdata = 16'h0000;
        repeat (2) @(negedge clk);

        // Values while reset is held.
        chk("rst_req_ready", 32'(rr1), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata1), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err1), 32'd0);
        chk("rst_ram_en", 32'(ram_en1), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr1), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata1), 32'd0);
        rst = 1'b0; mem_load = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", 32'(rr1), 32'd1);

        // Vector table.
        for (int i = 0; i < 13; i++) begin
            if (!vecs[i].sel)
                model(vecs[i].we, vecs[i].wide, vecs[i].addr, vecs[i].wdata, 1, m_rd, m_err, m_lat, m_beats);
            do_req(vecs[i].sel, vecs[i].we, vecs[i].wide, vecs[i].addr, vecs[i].wdata, 1'b0,
                   got_rd, got_err, got_lat, got_beats, bad);
            chk($sformatf("vec%0d_rdata", i), 32'(got_rd), 32'(vecs[i].exp_rdata));
            chk($sformatf("vec%0d_err", i), 32'(got_err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_latency", i), 32'(got_lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_ram_beats", i), 32'(got_beats), 32'(vecs[i].exp_beats));
            chk($sformatf("vec%0d_busy_ready", i), 32'(bad), 32'd0);
        end
        @(negedge clk);
        chk("mem_0x20", 32'(mem1[8'h20]), 32'h00EF);
        chk("mem_0x21", 32'(mem1[8'h21]), 32'h0099);
        chk("mem_0x00_wrap", 32'(mem1[8'h00]), WRAP_EN ? 32'h03 : 32'h12);

        // Four requests with req_valid held high throughout.
        p0 = pulses1;
        model(1, 0, 8'h40, 16'h0011, 1, m_rd, m_err, m_lat, m_beats);
        do_req(0, 1, 0, 8'h40, 16'h0011, 1'b1, got_rd, got_err, got_lat, got_beats, bad);
        chk("b2b0_latency", 32'(got_lat), 32'd2);
        chk("b2b0_busy_ready", 32'(bad), 32'd0);
        model(1, 0, 8'h41, 16'h0022, 1, m_rd, m_err, m_lat, m_beats);
        do_req(0, 1, 0, 8'h41, 16'h0022, 1'b1, got_rd, got_err, got_lat, got_beats, bad);
        chk("b2b1_latency", 32'(got_lat), 32'd2);
        model(0, 1, 8'h40, 16'h0000, 1, m_rd, m_err, m_lat, m_beats);
        do_req(0, 0, 1, 8'h40, 16'h0000, 1'b1, got_rd, got_err, got_lat, got_beats, bad);
        chk("b2b2_rdata", 32'(got_rd), 32'h2211);
        chk("b2b2_busy_ready", 32'(bad), 32'd0);
        model(0, 0, 8'h41, 16'h0000, 1, m_rd, m_err, m_lat, m_beats);
        do_req(0, 0, 0, 8'h41, 16'h0000, 1'b0, got_rd, got_err, got_lat, got_beats, bad);
        chk("b2b3_rdata", 32'(got_rd), 32'h0022);
        chk("b2b3_latency", 32'(got_lat), 32'd3);
        repeat (3) @(negedge clk);
        chk("b2b_pulse_count", 32'(pulses1 - p0), 32'd4);

        // Reset asserted during the first WAIT cycle of a halfword load.
        p0 = pulses1;
        req_we = 1'b0; req_wide = 1'b1; req_addr = 8'h50; req_wdata = 16'h0000; rv1 = 1'b1;
        @(posedge clk);          // accept edge
        @(negedge clk);          // ISSUE
        rv1 = 1'b0;
        @(negedge clk);          // WAIT
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ram_en", 32'(ram_en1), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid1), 32'd0);
        chk("midrst_req_ready_in_rst", 32'(rr1), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_req_ready_after", 32'(rr1), 32'd1);
        repeat (4) @(negedge clk);
        chk("midrst_no_response", 32'(pulses1 - p0), 32'd0);
        model(0, 1, 8'h40, 16'h0000, 1, m_rd, m_err, m_lat, m_beats);
        do_req(0, 0, 1, 8'h40, 16'h0000, 1'b0, got_rd, got_err, got_lat, got_beats, bad);
        chk("midrst_next_rdata", 32'(got_rd), 32'(m_rd));
        chk("midrst_next_latency", 32'(got_lat), 32'(m_lat));

        // Randomized stream checked against the reference model.
        for (int i = 0; i < 60; i++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_wide  = 1'($urandom_range(0, 1));
            r_addr  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            r_wdata = 16'($urandom_range(0, 65535));
            r_hold  = (i < 59) && ($urandom_range(0, 1) == 1);
            model(r_we, r_wide, r_addr, r_wdata, 1, m_rd, m_err, m_lat, m_beats);
            do_req(0, r_we, r_wide, r_addr, r_wdata, r_hold, got_rd, got_err, got_lat, got_beats, bad);
            chk($sformatf("rnd%0d_rdata", i), 32'(got_rd), 32'(m_rd));
            chk($sformatf("rnd%0d_err", i), 32'(got_err), 32'(m_err));
            chk($sformatf("rnd%0d_latency", i), 32'(got_lat), 32'(m_lat));
            chk($sformatf("rnd%0d_ram_beats", i), 32'(got_beats), 32'(m_beats));
        end
        repeat (3) @(negedge clk);

        mism = 0;
        for (int i = 0; i < 256; i++) if (mem1[i] !== ref_mem[i]) mism++;
        chk("ram_contents_mismatches", 32'(mism), 32'd0);
        chk("rsp_pulses_longer_than_1", 32'(wide_pulses), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Request sequencer directly upstream of the 8-bit single-port byte RAM (256 x 8, gated by en, r_w 0=read/1=write, registered read data).
- Accepts byte or 16-bit halfword load/store requests from the CPU datapath over a valid/ready handshake.
- Breaks each request into per-byte RAM beats and returns one response pulse per request.
- Halfwords are little-endian: low byte at addr, high byte at addr+1.

Parameters:
- ADDR_W, 8, RAM address width. Fixed at 8 for the current RAM.
- RD_LAT, 1, cycles between a RAM read beat and ram_rdata being valid. Must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_we  input  1  0 = load, 1 = store.
- req_wide  input  1  0 = byte, 1 = halfword.
- req_addr  input  8  byte address.
- req_wdata  input  16  store data. Byte access uses [7:0].
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  16  load result. Byte loads are zero-extended. Stores return 0.
- rsp_err  output  1  error flag, valid with rsp_valid. See Optional Feature.
- ram_en  output  1  to RAM en.
- ram_r_w  output  1  to RAM r_w.
- ram_addr  output  8  to RAM addr_in.
- ram_wdata  output  8  to RAM data_in.
- ram_rdata  input  8  from RAM data_out.

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE, beat=0, latched request cleared.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - ram_en=0, ram_r_w=0, ram_addr=0, ram_wdata=0.
  - req_ready is 0 while rst is high and 1 in IDLE afterwards.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are decoded from registered state and latched request only (Moore).
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready: latch we/wide/addr/wdata, set beat=0, go to ISSUE.
- ISSUE:
  - ram_en=1, ram_r_w=we.
  - ram_addr = addr+beat, computed 8-bit modulo.
  - ram_wdata = wdata byte[beat].
  - Store: if this is the last beat go to RESP, else beat<=1 and stay in ISSUE.
  - Load: go to WAIT.
- WAIT:
  - ram_en=0. Lasts RD_LAT cycles, counted by an internal counter.
  - On the final WAIT cycle, capture ram_rdata into result byte[beat].
  - Then go to RESP if last beat, else beat<=1 and go to ISSUE.
- RESP:
  - rsp_valid=1 for exactly one cycle, with rsp_rdata/rsp_err valid in the same cycle.
  - Go to IDLE.
  - No response backpressure; the consumer must take the response that cycle.
- Latency, request accepted at edge T, with RD_LAT=1 (cycles in RESP):
  - byte store: T+2
  - halfword store: T+3
  - byte load: T+3
  - halfword load: T+5
- req_ready=0 in ISSUE/WAIT/RESP. The requester holds req_* stable until accepted. req_valid while busy is ignored.
- Back-to-back requests: the earliest next accept is the cycle after RESP, with IDLE lasting at least one cycle.
- rsp_rdata holds its value until the next RESP. It is cleared only by reset.
- Address wrap: a halfword at 0xFF accesses 0xFF then 0x00 (without the feature).
- Reset mid-operation: the request is aborted and no rsp_valid is produced. ram_en is 0 from the cycle after the reset edge. A halfword store that completed beat 0 is not rolled back (partial write allowed).

Optional Feature:
- Macro: MEM_CTRL_WRAP_ERR_EN
- Defined:
  - A halfword request with addr=0xFF issues no RAM beat.
  - ISSUE is skipped: IDLE goes to RESP directly.
  - rsp_valid asserts with rsp_err=1 and rsp_rdata=0.
  - All other requests give rsp_err=0.
- Undefined:
  - rsp_err is tied 0.
  - A halfword at 0xFF wraps to 0x00 as above.

Test Plan:
- Byte store 0xA5 to 0x10, then byte load 0x10 -> one ram_en write beat (addr 0x10, wdata 0xA5); load rsp_rdata=0x00A5 three cycles after accept.
- Halfword store 0xBEEF to 0x20, then halfword load 0x20 -> RAM[0x20]=0xEF, RAM[0x21]=0xBE; rsp_rdata=0xBEEF at accept+5.
- Halfword store 0x1234 to 0xFF (macro off) -> RAM[0xFF]=0x34, RAM[0x00]=0x12, rsp_err=0. Macro on -> no ram_en, rsp_valid at accept+1 with rsp_err=1, rsp_rdata=0.
- req_valid held high for 4 consecutive requests -> req_ready low while busy; exactly 4 rsp_valid pulses, each 1 cycle; no request dropped or duplicated.
- rst asserted in the WAIT of a halfword load -> no rsp_valid, ram_en=0 the cycle after reset, req_ready=1 once rst drops, and the next request completes correctly.
- RD_LAT=2 build, byte load -> WAIT lasts 2 cycles, rsp_valid at accept+4 with correct data.
